// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: state encoding and line levels shared by the serial transmitter.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_baud.sv
// baud_tick_counter: counts clock cycles within a bit period and flags the last one.
module baud_tick_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && cnt == CW'(CLKS_PER_BIT - 1);

    // Held at zero while disabled so every frame starts on a fresh bit period.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) cnt <= '0;
        else        cnt <= (en && !tick) ? cnt + 1'b1 : '0;
    end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serialises a handshaked parallel word as start, LSB-first data,
// optional even parity and stop bit on an idle-high line.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             txd,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] shift, shift_next;
    logic [BW-1:0]    bit_cnt, bit_cnt_next;
    logic             parity, parity_next, txd_next, tick, last_bit;

    baud_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .clear(clear),
        .en   (busy),
        .tick (tick)
    );

    assign busy     = state != IDLE;
    assign in_ready = state == IDLE;
    assign done     = state == STOP && tick;
    assign last_bit = bit_cnt == BW'(WIDTH - 1);

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        parity_next  = parity;
        case (state)
            IDLE: if (in_valid) begin
                state_next   = START;
                shift_next   = in_data;
                parity_next  = ^in_data;
                bit_cnt_next = '0;
            end
            START:  if (tick) state_next = DATA;
            DATA: if (tick) begin
                shift_next   = shift >> 1;
                bit_cnt_next = last_bit ? '0 : bit_cnt + 1'b1;
                if (last_bit) state_next = PARITY_EN ? PARITY : STOP;
            end
            PARITY: if (tick) state_next = STOP;
            STOP:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // txd is registered from the upcoming state so the line changes exactly on bit boundaries.
        txd_next = state_next == START  ? START_BIT :
                   state_next == DATA   ? shift_next[0] :
                   state_next == PARITY ? parity_next :
                   state_next == STOP   ? STOP_BIT : LINE_IDLE;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            parity  <= 1'b0;
            txd     <= LINE_IDLE;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            parity  <= parity_next;
            txd     <= txd_next;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed frame vectors across three configurations of serial_frame_tx.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       clear;
    logic [7:0] in_data;
    logic       in_valid;
    logic [1:0] sel;

    logic rdy0, txd0, busy0, done0;
    logic rdy1, txd1, busy1, done1;
    logic rdy2, txd2, busy2, done2;
    logic m_rdy, m_txd, m_busy, m_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx dut (
        .clk(clk), .clear(clear), .in_data(in_data), .in_valid(in_valid && sel == 2'd0),
        .in_ready(rdy0), .txd(txd0), .busy(busy0), .done(done0)
    );

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_np (
        .clk(clk), .clear(clear), .in_data(in_data), .in_valid(in_valid && sel == 2'd1),
        .in_ready(rdy1), .txd(txd1), .busy(busy1), .done(done1)
    );

    serial_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1'b1)) dut_c1 (
        .clk(clk), .clear(clear), .in_data(in_data[3:0]), .in_valid(in_valid && sel == 2'd2),
        .in_ready(rdy2), .txd(txd2), .busy(busy2), .done(done2)
    );

    assign m_rdy  = sel == 2'd0 ? rdy0  : sel == 2'd1 ? rdy1  : rdy2;
    assign m_txd  = sel == 2'd0 ? txd0  : sel == 2'd1 ? txd1  : txd2;
    assign m_busy = sel == 2'd0 ? busy0 : sel == 2'd1 ? busy1 : busy2;
    assign m_done = sel == 2'd0 ? done0 : sel == 2'd1 ? done1 : done2;

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [10:0] frame;
        int          nbits;
        int          cpb;
        bit          inject;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_idle_txd"}, m_txd, 1);
        chk({tag, "_idle_busy"}, m_busy, 0);
        chk({tag, "_idle_ready"}, m_rdy, 1);
        chk({tag, "_idle_done"}, m_done, 0);
    endtask

    task automatic accept(input logic [7:0] d);
        @(negedge clk);
        chk("ready_before_accept", m_rdy, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic run_frame(input logic [10:0] f, input int nbits, input int cpb, input bit inject);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                chk($sformatf("txd_b%0d_c%0d", b, c), m_txd, f[b]);
                chk("busy_in_frame", m_busy, 1);
                chk("ready_in_frame", m_rdy, 0);
                chk($sformatf("done_b%0d_c%0d", b, c), m_done, (b == nbits - 1 && c == cpb - 1));
                if (inject) begin
                    in_valid = (b == 4 && c == 1);
                    in_data  = 8'h3C;
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 8'hA5, 11'h54A, 11, 4, 1'b0};
        vecs[1] = '{2'd0, 8'h07, 11'h60E, 11, 4, 1'b0};
        vecs[2] = '{2'd1, 8'h07, 11'h20E, 10, 4, 1'b0};
        vecs[3] = '{2'd2, 8'h09, 11'h052, 7, 1, 1'b0};
        vecs[4] = '{2'd0, 8'h5A, 11'h4B4, 11, 4, 1'b1};
        vecs[5] = '{2'd2, 8'h07, 11'h06E, 7, 1, 1'b0};
        vecs[6] = '{2'd1, 8'h80, 11'h300, 10, 4, 1'b0};

        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        sel      = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_txd", m_txd, 1);
        chk("rst_busy", m_busy, 0);
        chk("rst_ready", m_rdy, 1);
        chk("rst_done", m_done, 0);
        clear = 1'b1;

        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel;
            accept(vecs[i].data);
            run_frame(vecs[i].frame, vecs[i].nbits, vecs[i].cpb, vecs[i].inject);
            in_valid = 1'b0;
            idle_check($sformatf("vec%0d", i));
            if (vecs[i].inject)
                repeat (6) begin
                    @(negedge clk);
                    chk("rejected_word_txd", m_txd, 1);
                    chk("rejected_word_busy", m_busy, 0);
                end
        end

        // Back-to-back with in_valid held: exactly one idle cycle between frames.
        sel = 2'd0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(posedge clk);
        #1 in_data = 8'hFF;
        run_frame(11'h400, 11, 4, 1'b0);
        @(negedge clk);
        chk("b2b_gap_txd", m_txd, 1);
        chk("b2b_gap_ready", m_rdy, 1);
        chk("b2b_gap_busy", m_busy, 0);
        run_frame(11'h5FE, 11, 4, 1'b0);
        in_valid = 1'b0;
        idle_check("b2b");

        // Reset during DATA bit 3 abandons the frame at once.
        accept(8'hA5);
        repeat (17) @(negedge clk);
        chk("pre_reset_d3_txd", m_txd, 0);
        chk("pre_reset_busy", m_busy, 1);
        #1 clear = 1'b0;
        #1;
        chk("mid_reset_txd", m_txd, 1);
        chk("mid_reset_busy", m_busy, 0);
        chk("mid_reset_ready", m_rdy, 1);
        chk("mid_reset_done", m_done, 0);
        @(negedge clk);
        clear = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_no_done", m_done, 0);
            chk("post_reset_txd", m_txd, 1);
        end
        accept(8'hA5);
        run_frame(11'h54A, 11, 4, 1'b0);
        idle_check("post_reset");

        // in_valid asserted while in reset is only taken once clear is high before an edge.
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        chk("no_accept_in_reset_busy", m_busy, 0);
        chk("no_accept_in_reset_txd", m_txd, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        run_frame(11'h4B4, 11, 4, 1'b0);
        idle_check("release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
